rom_msg_streamer: RTL and testbench
===================================

Name: rom_msg_streamer

Overview:
Parametrised character ROM with a built-in sequencer. On a start command it streams a programmable run of ROM entries (start address, length, optional wrap and loop) over a valid/ready output with backpressure. A second, independent registered random-access read port serves direct lookups. It is the successor to the fixed 16x8 combinational name ROM and drives text/banner output paths.

Parameters:
DATA_W, 8, entry width; must be >= 8; 8-bit contents zero-extended.
DEPTH, 16, number of ROM entries; must be a power of two.
ADDR_W, 4, address width; equals log2(DEPTH).

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  start a stream; honoured in IDLE or DONE only
start_addr  in  ADDR_W  first entry of the stream
len  in  ADDR_W+1  entries per pass; 0 = empty stream; values > DEPTH clamp to DEPTH
loop_en  in  1  1 = repeat the pass until abort; sampled with start
abort  in  1  terminate the stream
out_ready  in  1  sink ready
out_data  out  DATA_W  streamed entry
out_valid  out  1  out_data valid
out_last  out  1  final entry of the current pass; qualified by out_valid
busy  out  1  high in STREAM
done  out  1  one-cycle pulse after a non-loop stream completes
rd_addr  in  ADDR_W  random-access read address
rd_data  out  DATA_W  entry at rd_addr, registered

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- ROM contents, index 0..15: "S","P","A","T","A","R","U","I","O","N","E","S","C","U","B", then decimal 56 (0x53 0x50 0x41 0x54 0x41 0x52 0x55 0x49 0x4F 0x4E 0x45 0x53 0x43 0x55 0x42 0x38). Index >= 16 holds 0.
- Reset (async assert, sync release): state IDLE; out_data, rd_data = 0; out_valid, out_last, busy, done = 0.
- States: IDLE, STREAM, DONE.
- IDLE/DONE + start, len > 0:
  - Latch start_addr, the clamped length and loop_en.
  - Next cycle: STREAM, out_valid = 1, out_data = ROM[start_addr], busy = 1.
  - Latency from start to first valid is 1 cycle.
- IDLE/DONE + start, len = 0: go to DONE for one cycle (done = 1). out_valid never asserts.
- start while in STREAM is ignored.
- STREAM handshake:
  - A transfer occurs when out_valid && out_ready.
  - While out_valid && !out_ready, out_data and out_last hold stable.
  - Throughput is 1 entry per cycle with out_ready held high.
  - After each transfer the address increments modulo DEPTH (DEPTH-1 wraps to 0).
- out_last = 1 on the entry whose count reaches the latched length.
- Transfer of the out_last entry:
  - loop_en = 0: next cycle DONE, out_valid = 0, busy = 0, done = 1. The following cycle is IDLE.
  - loop_en = 1: next cycle presents ROM[start_addr] again with no bubble. done never pulses.
- abort in STREAM (wins over a same-cycle transfer): next cycle IDLE, out_valid = 0, out_last = 0, busy = 0, no done. abort in IDLE/DONE also blocks a same-cycle start.
- DONE lasts exactly one cycle. A start during DONE is accepted as from IDLE.
- rd port: rd_data <= ROM[rd_addr] every cycle (1-cycle latency). Independent of stream state.
- Async reset mid-stream: outputs clear immediately and the stream is discarded.

Test Plan:
1. start_addr=0, len=16, loop_en=0, out_ready=1 -> out_data 0x53,0x50,0x41,0x54,0x41,0x52,0x55,0x49,0x4F,0x4E,0x45,0x53,0x43,0x55,0x42,0x38 on 16 consecutive cycles starting 1 cycle after start; out_last only with 0x38; done=1 on the next cycle; busy=0 there.
2. Wrap: start_addr=14, len=4 -> 0x42,0x38,0x53,0x50; out_last with 0x50. Clamp: len=20 from 0 -> exactly 16 entries.
3. Backpressure: len=3 from 5, out_ready low for 3 cycles after valid rises -> out_data holds 0x52 stable; then 0x52,0x55,0x49 transferred; no entry skipped or repeated.
4. Loop: start_addr=12, len=2, loop_en=1 -> 0x43,0x55,0x43,0x55,... gapless, out_last on each 0x55; abort -> out_valid=0 next cycle, done stays 0.
5. Edge commands: len=0 -> done pulse next cycle, out_valid never 1. start during STREAM -> ignored. rst_n low mid-stream -> out_valid=0 and busy=0 immediately.
6. rd port: rd_addr=5, then 15, then 3 during an active stream -> rd_data 0x52, 0x38, 0x54 each one cycle later; stream output unaffected.

Source files
------------

// File: rtl/rom_msg_streamer.sv
// ============================================================================
// Module      : rom_msg_streamer
// Description : Character ROM with a start/length/loop sequencer streaming
//               entries over valid/ready, plus a registered random-read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_msg_streamer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   len,
    input  logic              loop_en,
    input  logic              abort,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [ADDR_W:0] c_depth_len = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] c_one_len   = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [ADDR_W-1:0] r_start_addr, w_start_addr_nxt;
    logic [ADDR_W:0]   r_len, w_len_nxt;
    logic [ADDR_W:0]   r_cnt, w_cnt_nxt;
    logic [ADDR_W:0]   w_len_clamped;
    logic              r_loop, w_loop_nxt;
    logic [DATA_W-1:0] w_data_nxt;
    logic              w_valid_nxt, w_last_nxt, w_done_nxt;
    logic              w_xfer;
    logic [ADDR_W-1:0] w_addr_inc;

    // Message contents; anything beyond index 15 reads as zero.
    function automatic logic [DATA_W-1:0] rom_at(input logic [ADDR_W-1:0] a);
        logic [7:0] c;
        case (32'(a))
            0:       c = 8'h53;
            1:       c = 8'h50;
            2:       c = 8'h41;
            3:       c = 8'h54;
            4:       c = 8'h41;
            5:       c = 8'h52;
            6:       c = 8'h55;
            7:       c = 8'h49;
            8:       c = 8'h4F;
            9:       c = 8'h4E;
            10:      c = 8'h45;
            11:      c = 8'h53;
            12:      c = 8'h43;
            13:      c = 8'h55;
            14:      c = 8'h42;
            15:      c = 8'h38;
            default: c = 8'h00;
        endcase
        return DATA_W'(c);
    endfunction

    assign w_len_clamped = (len > c_depth_len) ? c_depth_len : len;
    assign w_xfer        = out_valid && out_ready;
    assign w_addr_inc    = r_addr + ADDR_W'(1);
    assign busy          = (r_state == S_STREAM);

    always_comb begin
        w_state_nxt      = r_state;
        w_addr_nxt       = r_addr;
        w_start_addr_nxt = r_start_addr;
        w_len_nxt        = r_len;
        w_cnt_nxt        = r_cnt;
        w_loop_nxt       = r_loop;
        w_data_nxt       = out_data;
        w_valid_nxt      = out_valid;
        w_last_nxt       = out_last;
        w_done_nxt       = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (r_state == S_DONE) begin
                    w_state_nxt = S_IDLE;
                end
                if (start && !abort) begin
                    if (len == '0) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt      = S_STREAM;
                        w_start_addr_nxt = start_addr;
                        w_len_nxt        = w_len_clamped;
                        w_loop_nxt       = loop_en;
                        w_addr_nxt       = start_addr;
                        w_cnt_nxt        = c_one_len;
                        w_data_nxt       = rom_at(start_addr);
                        w_valid_nxt      = 1'b1;
                        w_last_nxt       = (w_len_clamped == c_one_len);
                    end
                end
            end
            S_STREAM: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_valid_nxt = 1'b0;
                    w_last_nxt  = 1'b0;
                end else if (w_xfer) begin
                    if (out_last) begin
                        if (r_loop) begin
                            // Restart the pass with no bubble.
                            w_addr_nxt = r_start_addr;
                            w_cnt_nxt  = c_one_len;
                            w_data_nxt = rom_at(r_start_addr);
                            w_last_nxt = (r_len == c_one_len);
                        end else begin
                            w_state_nxt = S_DONE;
                            w_valid_nxt = 1'b0;
                            w_last_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                        end
                    end else begin
                        w_addr_nxt = w_addr_inc;
                        w_cnt_nxt  = r_cnt + c_one_len;
                        w_data_nxt = rom_at(w_addr_inc);
                        w_last_nxt = ((r_cnt + c_one_len) == r_len);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b0;
                w_last_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_start_addr <= '0;
            r_len        <= '0;
            r_cnt        <= '0;
            r_loop       <= 1'b0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            done         <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_addr       <= w_addr_nxt;
            r_start_addr <= w_start_addr_nxt;
            r_len        <= w_len_nxt;
            r_cnt        <= w_cnt_nxt;
            r_loop       <= w_loop_nxt;
            out_data     <= w_data_nxt;
            out_valid    <= w_valid_nxt;
            out_last     <= w_last_nxt;
            done         <= w_done_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= rom_at(rd_addr);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rom_msg_streamer.sv
// ============================================================================
// Module      : tb_rom_msg_streamer
// Description : Directed bench for rom_msg_streamer: pass table plus corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rom_msg_streamer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] start_addr = '0;
    logic [4:0] len = '0;
    logic       loop_en = 1'b0;
    logic       abort = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       busy;
    logic       done;
    logic [3:0] rd_addr = '0;
    logic [7:0] rd_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] rom [16] = '{8'h53, 8'h50, 8'h41, 8'h54, 8'h41, 8'h52, 8'h55, 8'h49,
                             8'h4F, 8'h4E, 8'h45, 8'h53, 8'h43, 8'h55, 8'h42, 8'h38};

    typedef struct {
        logic [3:0] sa;
        logic [4:0] ln;
        int         n;
        logic [7:0] first;
        logic [7:0] lastd;
    } vec_t;

    vec_t vecs [5];

    rom_msg_streamer #(.DATA_W(8), .DEPTH(16), .ADDR_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .len        (len),
        .loop_en    (loop_en),
        .abort      (abort),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where the first beat is visible.
    task automatic issue(input logic [3:0] a_sa, input logic [4:0] a_len, input logic a_loop);
        start      = 1'b1;
        start_addr = a_sa;
        len        = a_len;
        loop_en    = a_loop;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_pass(input vec_t v);
        logic [3:0] idx;
        issue(v.sa, v.ln, 1'b0);
        for (int i = 0; i < v.n; i++) begin
            idx = v.sa + 4'(i);
            check("pass_valid", 32'(out_valid), 32'd1);
            check("pass_busy", 32'(busy), 32'd1);
            check("pass_data", 32'(out_data), 32'(rom[idx]));
            check("pass_last", 32'(out_last), 32'(i == v.n - 1));
            if (i == 0) check("pass_first", 32'(out_data), 32'(v.first));
            if (i == v.n - 1) check("pass_lastdata", 32'(out_data), 32'(v.lastd));
            @(negedge clk);
        end
        check("pass_end_valid", 32'(out_valid), 32'd0);
        check("pass_end_done", 32'(done), 32'd1);
        check("pass_end_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("pass_done_once", 32'(done), 32'd0);
    endtask

    initial begin
        logic [7:0] bp_exp [3];
        logic [3:0] rd_seq [3];
        bp_exp = '{8'h52, 8'h55, 8'h49};
        rd_seq = '{4'd5, 4'd15, 4'd3};

        vecs[0] = '{sa: 4'd0,  ln: 5'd16, n: 16, first: 8'h53, lastd: 8'h38};
        vecs[1] = '{sa: 4'd14, ln: 5'd4,  n: 4,  first: 8'h42, lastd: 8'h50};
        vecs[2] = '{sa: 4'd0,  ln: 5'd20, n: 16, first: 8'h53, lastd: 8'h38};
        vecs[3] = '{sa: 4'd7,  ln: 5'd1,  n: 1,  first: 8'h49, lastd: 8'h49};
        vecs[4] = '{sa: 4'd15, ln: 5'd16, n: 16, first: 8'h38, lastd: 8'h42};

        // Reset state
        #3;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_rd", 32'(rd_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[k]) run_pass(vecs[k]);

        // Backpressure: stall three cycles on the first beat
        out_ready = 1'b0;
        issue(4'd5, 5'd3, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_data", 32'(out_data), 32'h52);
            check("bp_hold_last", 32'(out_last), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", 32'(out_data), 32'(bp_exp[b]));
            check("bp_last", 32'(out_last), 32'(b == 2));
            @(negedge clk);
        end
        check("bp_done", 32'(done), 32'd1);
        check("bp_end_valid", 32'(out_valid), 32'd0);
        @(negedge clk);

        // Loop then abort
        issue(4'd12, 5'd2, 1'b1);
        for (int b = 0; b < 6; b++) begin
            check("loop_valid", 32'(out_valid), 32'd1);
            check("loop_data", 32'(out_data), (b % 2 == 0) ? 32'h43 : 32'h55);
            check("loop_last", 32'(out_last), 32'(b % 2 == 1));
            check("loop_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_last", 32'(out_last), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        check("abort_done2", 32'(done), 32'd0);

        // Empty stream
        issue(4'd3, 5'd0, 1'b0);
        check("len0_done", 32'(done), 32'd1);
        check("len0_valid", 32'(out_valid), 32'd0);
        check("len0_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("len0_done2", 32'(done), 32'd0);
        check("len0_valid2", 32'(out_valid), 32'd0);

        // start while streaming is ignored
        issue(4'd0, 5'd3, 1'b0);
        check("ign_b0", 32'(out_data), 32'h53);
        start = 1'b1; start_addr = 4'd8; len = 5'd5;
        @(negedge clk);
        start = 1'b0;
        check("ign_b1", 32'(out_data), 32'h50);
        check("ign_b1_last", 32'(out_last), 32'd0);
        @(negedge clk);
        check("ign_b2", 32'(out_data), 32'h41);
        check("ign_b2_last", 32'(out_last), 32'd1);
        @(negedge clk);
        check("ign_done", 32'(done), 32'd1);
        check("ign_end_valid", 32'(out_valid), 32'd0);
        @(negedge clk);

        // Random-access port during a stream
        issue(4'd0, 5'd16, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("rd_stream_data", 32'(out_data), 32'(rom[4'(i)]));
            check("rd_stream_valid", 32'(out_valid), 32'd1);
            if (i >= 1 && i <= 3) check("rd_data", 32'(rd_data), 32'(rom[rd_seq[i-1]]));
            if (i < 3) rd_addr = rd_seq[i];
            @(negedge clk);
        end
        for (int i = 5; i < 16; i++) @(negedge clk);
        check("rd_stream_done", 32'(done), 32'd1);
        @(negedge clk);

        // Async reset mid-stream
        issue(4'd0, 5'd16, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("ar_pre_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ar_after_valid", 32'(out_valid), 32'd0);
        check("ar_after_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
